piso_tx_ctrl: RTL and testbench

Sequencing controller for the parallel-in/serial-out register path. It accepts a parallel word over a valid/ready handshake, holds it in an internal shift register, and streams it out one bit per accepted cycle under downstream backpressure. It marks frame boundaries and can insert an idle gap between frames. It sits between the word source and the serial consumer, replacing hand-driven load strobing.

---
 rtl/piso_tx_ctrl.sv | 156 +++++++++++++++
 tb/tb_piso_tx_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// piso_tx_ctrl
// Parallel-in / serial-out sequencing controller. Accepts a WIDTH-bit word on a
// valid/ready handshake, then streams it one bit per accepted cycle under
// downstream backpressure, flags the first and last bit of each frame, and
// optionally holds off the next word for GAP_CYCLES idle cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     parallel word available
//   in_ready     controller can accept a word this cycle (IDLE)
//   in_data      parallel word, sampled on in_valid && in_ready
//   ser_ready    downstream accepts the current serial bit
//   ser_valid    ser_out holds a valid bit (SHIFT)
//   ser_out      current serial bit
//   frame_start  current ser_out is the first bit of a frame
//   frame_done   last bit of a frame transfers this cycle
//   busy         high in SHIFT or GAP
// -----------------------------------------------------------------------------
module piso_tx_ctrl #(
   parameter int WIDTH      = 4,
   parameter bit LSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             ser_ready,
   output logic             ser_valid,
   output logic             ser_out,
   output logic             frame_start,
   output logic             frame_done,
   output logic             busy
);

   // Counter widths; guarded so an illegal WIDTH still elaborates far enough
   // to reach the fatal check below.
   localparam int unsigned CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int unsigned GCNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam bit          HAS_GAP = (GAP_CYCLES > 0);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIDTH - 1);
   // Only reachable when HAS_GAP, so the wrap for GAP_CYCLES==0 is harmless.
   localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES - 1);

   // Elaboration-time parameter legality
   generate
      if (WIDTH < 2) begin : g_bad_width
         $fatal(1, "piso_tx_ctrl: WIDTH must be >= 2");
      end
      if (GAP_CYCLES < 0) begin : g_bad_gap
         $fatal(1, "piso_tx_ctrl: GAP_CYCLES must be >= 0");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_shreg;
   logic [CNT_W-1:0]   r_cnt;
   logic [GCNT_W-1:0]  r_gcnt;

   state_t             w_state_nxt;
   logic [WIDTH-1:0]   w_shreg_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [GCNT_W-1:0]  w_gcnt_nxt;

   logic               w_accept;
   logic               w_xfer;
   logic               w_last_bit;
   logic               w_send_bit;

   // Output decode from registered state; frame_done alone also sees ser_ready
   always_comb begin
      in_ready    = (r_state == ST_IDLE);
      busy        = (r_state != ST_IDLE);
      ser_valid   = (r_state == ST_SHIFT);
      w_send_bit  = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
      ser_out     = ser_valid ? w_send_bit : 1'b0;
      w_last_bit  = (r_cnt == CNT_LAST);
      w_xfer      = ser_valid && ser_ready;
      w_accept    = in_valid && in_ready;
      frame_start = ser_valid && (r_cnt == '0);
      frame_done  = w_xfer && w_last_bit;
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      w_gcnt_nxt  = r_gcnt;

      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_shreg_nxt = in_data;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (w_xfer) begin
               // Move the next bit to the send end; vacated bit fills with 0
               w_shreg_nxt = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
               if (w_last_bit) begin
                  w_cnt_nxt = '0;
                  if (HAS_GAP) begin
                     w_gcnt_nxt  = '0;
                     w_state_nxt = ST_GAP;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end

         ST_GAP: begin
            w_gcnt_nxt = r_gcnt + GCNT_W'(1);
            if (r_gcnt == GCNT_LAST) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_gcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gcnt  <= w_gcnt_nxt;
      end
   end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_piso_tx_ctrl
// Self-checking bench for piso_tx_ctrl. Three instances cover LSB-first
// (no gap), MSB-first (no gap) and LSB-first with a two-cycle gap. A negedge
// monitor keeps a bit-level scoreboard for the active instance; a vector table
// and hand-written sequences check frame timing and corner cases.
// -----------------------------------------------------------------------------
module tb_piso_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] in_valid;
   logic [2:0] ser_ready;
   logic [3:0] in_data [3];
   logic [2:0] in_ready, ser_valid, ser_out, frame_start, frame_done, busy;

   int n_cmp = 0;
   int n_bad = 0;
   int act   = 0;
   int pos   = 0;
   bit exp_q [$];

   always #5 clk = ~clk;

   piso_tx_ctrl #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .ser_ready(ser_ready[0]), .ser_valid(ser_valid[0]),
      .ser_out(ser_out[0]), .frame_start(frame_start[0]),
      .frame_done(frame_done[0]), .busy(busy[0]));

   piso_tx_ctrl #(.WIDTH(4), .LSB_FIRST(1'b0), .GAP_CYCLES(0)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .ser_ready(ser_ready[1]), .ser_valid(ser_valid[1]),
      .ser_out(ser_out[1]), .frame_start(frame_start[1]),
      .frame_done(frame_done[1]), .busy(busy[1]));

   piso_tx_ctrl #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP_CYCLES(2)) u_gap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data[2]), .ser_ready(ser_ready[2]), .ser_valid(ser_valid[2]),
      .ser_out(ser_out[2]), .frame_start(frame_start[2]),
      .frame_done(frame_done[2]), .busy(busy[2]));

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
   endtask

   // Bits in transmission order, first bit in [3]
   function automatic logic [3:0] send_order(input logic [3:0] d, input bit lsb);
      return lsb ? {d[0], d[1], d[2], d[3]} : d;
   endfunction

   function automatic logic [5:0] outs(input int k);
      return {in_ready[k], ser_valid[k], ser_out[k], frame_start[k],
              frame_done[k], busy[k]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor for the active instance
   always @(negedge clk) begin
      logic [3:0] o;
      int k;
      k = act;
      if (!rst_n) begin
         exp_q.delete();
         pos = 0;
      end else begin
         check("mon_ser_valid", ser_valid[k], exp_q.size() != 0);
         check("mon_busy", busy[k], !in_ready[k]);
         if (exp_q.size() != 0) begin
            check("mon_ser_out", ser_out[k], exp_q[0]);
            check("mon_frame_start", frame_start[k], pos == 0);
            check("mon_frame_done", frame_done[k], ser_ready[k] && pos == 3);
            check("mon_in_ready_busy", in_ready[k], 1'b0);
            if (ser_ready[k]) begin
               void'(exp_q.pop_front());
               pos = (pos == 3) ? 0 : pos + 1;
            end
         end else begin
            check("mon_idle_outs", {ser_out[k], frame_start[k], frame_done[k]}, 3'b000);
         end
         if (in_valid[k] && in_ready[k]) begin
            o = send_order(in_data[k], k != 1);
            for (int i = 3; i >= 0; i--) exp_q.push_back(o[i]);
            pos = 0;
         end
      end
   end

   // Send one word with an optional initial stall; checks frame timing
   task automatic send(input int k, input logic [3:0] d, input logic [3:0] seq,
                       input int stall, input int gap);
      logic [3:0] got;
      int c, c_done;
      bit done;
      act = k;
      got = '0;
      done = 1'b0;
      c_done = 0;
      in_data[k] = d;
      in_valid[k] = 1'b1;
      ser_ready[k] = 1'b1;
      c = 0;
      while (!in_ready[k]) begin
         tick();
         c++;
         if (c > 40) begin
            timeout("send_accept");
            in_valid[k] = 1'b0;
            return;
         end
      end
      tick();
      in_valid[k] = 1'b0;
      c = 1;
      while (!done) begin
         ser_ready[k] = (c > stall);
         #1;
         if (ser_valid[k] && ser_ready[k]) got = {got[2:0], ser_out[k]};
         if (frame_done[k]) begin
            done = 1'b1;
            c_done = c;
         end else begin
            tick();
            c++;
            if (c > 40) begin
               timeout("send_frame_done");
               return;
            end
         end
      end
      check("send_done_cycle", c_done, 4 + stall);
      check("send_sequence", got, seq);
      for (int g = 0; g < gap; g++) begin
         tick();
         check("send_gap_hold", {in_ready[k], ser_valid[k], busy[k]}, 3'b001);
      end
      tick();
      check("send_ready_after", {in_ready[k], busy[k]}, 2'b10);
   endtask

   typedef struct {
      int         k;
      logic [3:0] d;
      logic [3:0] seq;
      int         stall;
      int         gap;
   } vec_t;

   vec_t tbl [6];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e;
      logic [3:0] d;
      int c, nfd;
      bit ok;

      tbl[0] = '{k: 0, d: 4'b1011, seq: 4'b1101, stall: 0, gap: 0};
      tbl[1] = '{k: 1, d: 4'b1011, seq: 4'b1011, stall: 2, gap: 0};
      tbl[2] = '{k: 2, d: 4'hA,    seq: 4'b0101, stall: 0, gap: 2};
      tbl[3] = '{k: 0, d: 4'h3,    seq: 4'b1100, stall: 0, gap: 0};
      tbl[4] = '{k: 1, d: 4'h6,    seq: 4'b0110, stall: 1, gap: 0};
      tbl[5] = '{k: 2, d: 4'h9,    seq: 4'b1001, stall: 3, gap: 2};

      rst_n = 1'b0;
      in_valid = '0;
      ser_ready = '0;
      for (int k = 0; k < 3; k++) in_data[k] = '0;

      // Reset and idle
      repeat (3) begin
         tick();
         for (int k = 0; k < 3; k++) check("reset_outs", outs(k), 6'b100000);
      end
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         for (int k = 0; k < 3; k++) check("idle_outs", outs(k), 6'b100000);
      end

      // Vector table
      foreach (tbl[i]) send(tbl[i].k, tbl[i].d, tbl[i].seq, tbl[i].stall, tbl[i].gap);

      // A few random words on both no-gap instances
      for (int r = 0; r < 4; r++) begin
         d = 4'($urandom_range(0, 15));
         send(r % 2, d, send_order(d, (r % 2) == 0), r % 3, 0);
      end

      // Gap with in_valid held high carrying the next word
      act = 2;
      ser_ready[2] = 1'b1;
      in_data[2] = 4'hA;
      in_valid[2] = 1'b1;
      tick();
      in_data[2] = 4'h5;
      c = 1;
      ok = 1'b0;
      while (!ok && c <= 20) begin
         if (frame_done[2]) ok = 1'b1;
         else begin
            tick();
            c++;
         end
      end
      if (!ok) timeout("gap_frame_done");
      check("gap_done_cycle", c, 4);
      repeat (2) begin
         tick();
         check("gap_blocked", {in_ready[2], ser_valid[2]}, 2'b00);
      end
      tick();
      check("gap_reopen", in_ready[2], 1'b1);
      tick();
      in_valid[2] = 1'b0;
      e = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         check("gap_next_bit", ser_out[2], e[3-i]);
         check("gap_next_done", frame_done[2], i == 3);
         tick();
      end
      repeat (2) tick();

      // Back-to-back frames with in_valid held continuously
      act = 0;
      ser_ready[0] = 1'b1;
      in_data[0] = 4'hA;
      in_valid[0] = 1'b1;
      tick();
      in_data[0] = 4'h5;
      nfd = 0;
      ok = 1'b0;
      for (c = 1; c <= 15 && !ok; c++) begin
         if (c == 6) in_valid[0] = 1'b0;
         if (c == 4 || c == 6) check("b2b_not_ready", in_ready[0], 1'b0);
         if (c == 5) check("b2b_idle_gap", in_ready[0], 1'b1);
         if (frame_done[0]) begin
            nfd++;
            if (nfd == 2) begin
               check("b2b_second_done", c, 9);
               ok = 1'b1;
            end
         end
         if (!ok) tick();
      end
      if (!ok) timeout("b2b_second_done");
      in_valid[0] = 1'b0;
      repeat (2) tick();

      // Reset mid-frame
      act = 0;
      in_data[0] = 4'hF;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      repeat (2) tick();
      check("midrst_before", ser_valid[0], 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_async", outs(0), 6'b100000);
      repeat (2) begin
         tick();
         check("midrst_hold", outs(0), 6'b100000);
      end
      rst_n = 1'b1;
      #1;
      check("midrst_release", outs(0), 6'b100000);
      send(0, 4'h3, 4'b1100, 0, 0);

      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
